// File: rtl/mmio_timer.sv
// Memory-mapped prescaled countdown timer with sticky expiry flag.
// Optional interrupt output enabled by defining MMIO_TIMER_IRQ_EN.
module mmio_timer #(
  parameter int unsigned data_width = 16,
  parameter logic [8:0]  base_addr  = 9'h180,
  parameter logic [1:0]  MWRITE     = 2'b01,
  parameter logic [1:0]  MREAD      = 2'b11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mem_cmd,
  input  logic [8:0]            mem_addr,
  input  logic [data_width-1:0] wdata,
  output logic [data_width-1:0] rdata,
  output logic                  rd_hit,
  output logic                  irq
);

  localparam logic [data_width-1:0] one_c = {{(data_width-1){1'b0}}, 1'b1};

  logic [data_width-1:0] load_q, load_d;
  logic [data_width-1:0] count_q, count_d;
  logic [7:0]            presc_q, presc_d;
  logic [7:0]            pcnt_q, pcnt_d;
  logic                  en_q, en_d;
  logic                  periodic_q, periodic_d;
  logic                  expired_q, expired_d;
  logic                  irq_en_s;
  logic                  hit_s;
  logic                  wr_s;
  logic                  tick_s;
  logic                  expire_s;
  logic                  unused_s;

`ifdef MMIO_TIMER_IRQ_EN
  logic irq_en_q, irq_en_d;

  assign irq_en_s = irq_en_q;
  assign irq      = expired_q & irq_en_q;
  assign unused_s = ^wdata[7:3];

  // Interrupt-enable register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
    end
  end

  // IRQ_EN follows any CTRL write.
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_s && (mem_addr[1:0] == 2'd1)) begin
      irq_en_d = wdata[2];
    end else begin
      irq_en_d = irq_en_q;
    end
  end
`else
  assign irq_en_s = 1'b0;
  assign irq      = 1'b0;
  assign unused_s = ^wdata[7:2];
`endif

  assign hit_s    = (mem_addr[8:2] == base_addr[8:2]);
  assign rd_hit   = (mem_cmd == MREAD) && hit_s;
  assign wr_s     = (mem_cmd == MWRITE) && hit_s;
  assign tick_s   = en_q && (pcnt_q == presc_q);
  assign expire_s = tick_s && (count_q <= one_c);

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      load_q     <= '0;
      count_q    <= '0;
      presc_q    <= 8'd0;
      pcnt_q     <= 8'd0;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      load_q     <= load_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      expired_q  <= expired_d;
    end
  end

  // Countdown first, then bus writes override EN/COUNT on the same edge.
  always_comb begin
    load_d     = load_q;
    count_d    = count_q;
    presc_d    = presc_q;
    pcnt_d     = pcnt_q;
    en_d       = en_q;
    periodic_d = periodic_q;
    expired_d  = expired_q;

    if (tick_s) begin
      pcnt_d = 8'd0;
    end else if (en_q) begin
      pcnt_d = pcnt_q + 8'd1;
    end else begin
      pcnt_d = pcnt_q;
    end

    if (tick_s && !expire_s) begin
      count_d = count_q - one_c;
    end else if (expire_s) begin
      expired_d = 1'b1;
      if (periodic_q) begin
        count_d = load_q;
      end else begin
        count_d = '0;
        en_d    = 1'b0;
      end
    end else begin
      count_d = count_q;
    end

    if (wr_s) begin
      case (mem_addr[1:0])
        2'd0: load_d = wdata;
        2'd1: begin
          periodic_d = wdata[1];
          presc_d    = wdata[15:8];
          if (wdata[0] && !en_q) begin
            en_d    = 1'b1;
            count_d = load_q;
            pcnt_d  = 8'd0;
          end else if (wdata[0]) begin
            en_d = 1'b1;
            if (wdata[15:8] != presc_q) begin
              pcnt_d = 8'd0;
            end else begin
              pcnt_d = pcnt_d;
            end
          end else begin
            en_d    = 1'b0;
            count_d = count_q;
          end
        end
        2'd2: count_d = count_d;
        2'd3: begin
          if (wdata[0] && !expire_s) begin
            expired_d = 1'b0;
          end else begin
            expired_d = expired_d;
          end
        end
        default: load_d = load_q;
      endcase
    end else begin
      load_d = load_q;
    end
  end

  // Read mux; zero outside a read hit.
  always_comb begin
    rdata = '0;
    if (rd_hit) begin
      case (mem_addr[1:0])
        2'd0: rdata = load_q;
        2'd1: begin
          rdata[0]    = en_q;
          rdata[1]    = periodic_q;
          rdata[2]    = irq_en_s;
          rdata[15:8] = presc_q;
        end
        2'd2: rdata = count_q;
        2'd3: begin
          rdata[0] = expired_q;
          rdata[1] = en_q;
        end
        default: rdata = '0;
      endcase
    end else begin
      rdata = '0;
    end
  end

endmodule
